// File: rtl/xgmii_tlp_rx_engine_v2.sv
// XGMII receiver that filters UDP/IPv4 frames carrying encapsulated PCIe TLPs and
// writes 72-bit FIFO words (data + valid/last/DW-enable/abort flags), with statistics.
module xgmii_tlp_rx_engine_v2 #(
  parameter int          GAP       = 1,
  parameter logic [15:0] UDP_DPORT = 16'd3422,
  parameter logic [31:0] MAGIC     = 32'h2E7E_4E4D,
  parameter bit          CHECK_DST = 1'b0,
  parameter int          CNT_W     = 16
) (
  input  logic             xgmii_clk,
  input  logic             sys_rst,
  input  logic [7:0]       xgmii_rxc,
  input  logic [63:0]      xgmii_rxd,
  input  logic [31:0]      if_v4addr,
  input  logic [47:0]      if_macaddr,
  output logic [71:0]      din,
  input  logic             full,
  output logic             wr_en,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] tlp_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] abort_count,
  output logic [7:0]       led
);

  localparam int GAP_W = $clog2(GAP + 1) + 1;

  typedef enum logic [2:0] {IDLE, HEAD, TLP_START, TLP_BODY, GAP_FILL, DROP} state_t;

  state_t           state_q;
  logic [2:0]       hdr_idx_q;
  logic             match_q;
  logic [10:0]      rem_q;
  logic             odd_q;
  logic [GAP_W-1:0] gap_q;
  logic [71:0]      din_q;
  logic             wr_en_q;
  logic [CNT_W-1:0] frame_count_q, tlp_count_q, drop_count_q, abort_count_q;

  logic [7:0]  ln [8];
  logic        field_ok;
  logic [10:0] dw_len, tlp_n, tlp_words;

  for (genvar gi = 0; gi < 8; gi++) begin : g_lane
    assign ln[gi] = xgmii_rxd[8*gi +: 8];
  end

  // Header field check for the word currently indexed by hdr_idx_q (big-endian: first lane = MSB).
  always_comb begin
    field_ok = 1'b1;
    case (hdr_idx_q)
      3'd0: if (CHECK_DST) field_ok = ({ln[0], ln[1], ln[2], ln[3], ln[4], ln[5]} == if_macaddr);
      3'd1: field_ok = ({ln[4], ln[5]} == 16'h0800);
      3'd2: field_ok = (ln[7] == 8'h11);
      3'd3: if (CHECK_DST) field_ok = ({ln[6], ln[7]} == if_v4addr[31:16]);
      3'd4: field_ok = ({ln[4], ln[5]} == UDP_DPORT) &&
                       (!CHECK_DST || ({ln[0], ln[1]} == if_v4addr[15:0]));
      3'd5: field_ok = ({ln[2], ln[3], ln[4], ln[5]} == MAGIC);
      default: field_ok = 1'b0;
    endcase
  end

  // TLP size in DWs; a zero length field means 1024, so 11 bits keep it from wrapping.
  always_comb begin
    dw_len    = (xgmii_rxd[9:0] == 10'd0) ? 11'd1024 : {1'b0, xgmii_rxd[9:0]};
    tlp_n     = 11'd3 + {10'd0, xgmii_rxd[29]} + (xgmii_rxd[30] ? dw_len : 11'd0);
    tlp_words = (tlp_n + 11'd1) >> 1;
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state_q       <= IDLE;
      hdr_idx_q     <= '0;
      match_q       <= 1'b0;
      rem_q         <= '0;
      odd_q         <= 1'b0;
      gap_q         <= '0;
      din_q         <= '0;
      wr_en_q       <= 1'b0;
      frame_count_q <= '0;
      tlp_count_q   <= '0;
      drop_count_q  <= '0;
      abort_count_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      din_q   <= '0;
      case (state_q)
        IDLE: begin
          if (xgmii_rxc[0] && xgmii_rxd[7:0] == 8'hFB) begin
            state_q   <= HEAD;
            hdr_idx_q <= '0;
            match_q   <= 1'b1;
          end
        end
        HEAD: begin
          if (xgmii_rxc == 8'hFF) begin
            state_q <= IDLE;
          end else if (hdr_idx_q == 3'd5) begin
            if (match_q && field_ok) begin
              state_q       <= TLP_START;
              frame_count_q <= frame_count_q + CNT_W'(1);
            end else begin
              state_q <= IDLE;
            end
          end else begin
            hdr_idx_q <= hdr_idx_q + 3'd1;
            match_q   <= match_q & field_ok;
          end
        end
        TLP_START: begin
          if (xgmii_rxc != 8'h00) begin
            state_q <= GAP_FILL;
            gap_q   <= '0;
          end else if (full) begin
            state_q      <= DROP;
            drop_count_q <= drop_count_q + CNT_W'(1);
          end else begin
            wr_en_q <= 1'b1;
            din_q   <= {3'b000, 5'h0D, xgmii_rxd};
            rem_q   <= tlp_words - 11'd1;
            odd_q   <= tlp_n[0];
            state_q <= TLP_BODY;
          end
        end
        TLP_BODY: begin
          wr_en_q <= 1'b1;
          if (xgmii_rxc != 8'h00) begin
            din_q         <= {3'b000, 5'h13, 64'h0};
            abort_count_q <= abort_count_q + CNT_W'(1);
            state_q       <= GAP_FILL;
            gap_q         <= '0;
          end else if (rem_q == 11'd1) begin
            din_q       <= {3'b000, (odd_q ? 5'h07 : 5'h0F), xgmii_rxd};
            tlp_count_q <= tlp_count_q + CNT_W'(1);
            state_q     <= TLP_START;
          end else begin
            din_q <= {3'b000, 5'h0D, xgmii_rxd};
            rem_q <= rem_q - 11'd1;
          end
        end
        GAP_FILL: begin
          wr_en_q <= 1'b1;
          if (gap_q == GAP_W'(GAP)) state_q <= IDLE;
          else gap_q <= gap_q + GAP_W'(1);
        end
        DROP: begin
          if (xgmii_rxc != 8'h00) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign din         = din_q;
  assign wr_en       = wr_en_q;
  assign frame_count = frame_count_q;
  assign tlp_count   = tlp_count_q;
  assign drop_count  = drop_count_q;
  assign abort_count = abort_count_q;
  assign led         = frame_count_q[7:0];

endmodule
